// File: rtl/ram_pkg.sv
// Constants and types shared by the RAM-backed FIFO controller and its bench.
package ram_pkg;
    localparam int RAM_AW    = 8;
    localparam int RAM_DEPTH = 256;
    localparam int CNT_W     = 9;

    // Bypass needs an empty RAM and prefetch a non-empty one, and a write blocks
    // a prefetch, so exactly one of these happens in any cycle.
    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_BYPASS,
        ACT_WRITE,
        ACT_PREFETCH
    } ram_act_e;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external 256-deep single-port RAM with asynchronous
// read, plus a registered output word that bypasses the RAM when it is empty.
module ram_fifo_ctrl
    import ram_pkg::*;
#(
    parameter int DWL = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWL-1:0]    in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWL-1:0]    out_data,
    output logic              ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DWL-1:0]    ram_din,
    input  logic [DWL-1:0]    ram_dout,
    output logic [CNT_W-1:0]  count
);

    logic [RAM_AW-1:0] wr_ptr;
    logic [RAM_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]  ram_cnt;
    logic              push;
    logic              pop;
    logic              out_free;
    ram_act_e          act;

    assign in_ready = (ram_cnt != CNT_W'(RAM_DEPTH)) && rst_n;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

    always_comb begin
        // NOTE: default assigned first so every path drives act and no latch is inferred.
        act = ACT_IDLE;
        if (push && out_free && ram_cnt == '0) begin
            act = ACT_BYPASS;
        end else if (push) begin
            act = ACT_WRITE;
        end else if (out_free && ram_cnt != '0) begin
            act = ACT_PREFETCH;
        end
    end

    // The single RAM port points at the read head unless this cycle writes.
    assign ram_wen  = (act == ACT_WRITE);
    assign ram_addr = ram_wen ? wr_ptr : rd_ptr;
    assign ram_din  = in_data;
    assign count    = ram_cnt + CNT_W'(out_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (act)
                ACT_BYPASS: begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                end
                ACT_WRITE: begin
                    wr_ptr  <= wr_ptr + RAM_AW'(1);
                    ram_cnt <= ram_cnt + CNT_W'(1);
                    if (pop) out_valid <= 1'b0;
                end
                ACT_PREFETCH: begin
                    out_valid <= 1'b1;
                    out_data  <= ram_dout;
                    rd_ptr    <= rd_ptr + RAM_AW'(1);
                    ram_cnt   <= ram_cnt - CNT_W'(1);
                end
                default: begin
                    if (pop) out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural asynchronous-read RAM.
module tb_ram_fifo_ctrl;
    import ram_pkg::*;

    localparam int DWL = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DWL-1:0]    in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWL-1:0]    out_data;
    logic              ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    logic [DWL-1:0]    ram_din;
    logic [DWL-1:0]    ram_dout;
    logic [CNT_W-1:0]  count;

    logic [DWL-1:0] mem [RAM_DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DWL(DWL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .count     (count)
    );

    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    typedef struct {
        logic           iv;
        logic [DWL-1:0] din;
        logic           ordy;
        logic           exp_wen;
        logic           exp_ov;
        logic [DWL-1:0] exp_od;
        logic [8:0]     exp_cnt;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(logic iv, logic [31:0] din, logic ordy, logic wen,
                                logic ov, logic [31:0] od, logic [8:0] cnt);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.exp_wen = wen;
        v.exp_ov = ov; v.exp_od = od; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_vec(input int idx);
        in_valid  = vecs[idx].iv;
        in_data   = vecs[idx].din;
        out_ready = vecs[idx].ordy;
        #1;
        check($sformatf("vec%0d ram_wen", idx), 64'(ram_wen), 64'(vecs[idx].exp_wen));
        step();
        check($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(vecs[idx].exp_ov));
        check($sformatf("vec%0d out_data", idx), 64'(out_data), 64'(vecs[idx].exp_od));
        check($sformatf("vec%0d count", idx), 64'(count), 64'(vecs[idx].exp_cnt));
    endtask

    initial begin
        logic [DWL-1:0] sb [$];
        logic [DWL-1:0] exp_word;
        int sent, received, cycles, prev_wr, prev_rd;
        bit saw_wr_wrap, saw_rd_wrap;

        // Bypass after reset, hold while stalled, pop leaves out_data unchanged.
        vecs[0]  = mk(1, 32'hA5, 0, 0, 1, 32'hA5, 1);
        vecs[1]  = mk(0, 32'h00, 0, 0, 1, 32'hA5, 1);
        vecs[2]  = mk(0, 32'h00, 1, 0, 0, 32'hA5, 0);
        // Reach ram_cnt=3 with out_valid=0, then four pushes starve the prefetch.
        vecs[3]  = mk(1, 32'h11, 0, 0, 1, 32'h11, 1);
        vecs[4]  = mk(1, 32'h22, 0, 1, 1, 32'h11, 2);
        vecs[5]  = mk(1, 32'h33, 0, 1, 1, 32'h11, 3);
        vecs[6]  = mk(1, 32'h44, 1, 1, 0, 32'h11, 3);
        vecs[7]  = mk(1, 32'h55, 1, 1, 0, 32'h11, 4);
        vecs[8]  = mk(1, 32'h66, 1, 1, 0, 32'h11, 5);
        vecs[9]  = mk(1, 32'h77, 1, 1, 0, 32'h11, 6);
        vecs[10] = mk(1, 32'h88, 1, 1, 0, 32'h11, 7);
        vecs[11] = mk(0, 32'h00, 0, 0, 1, 32'h22, 7);
        vecs[12] = mk(0, 32'h00, 1, 0, 1, 32'h33, 6);
        vecs[13] = mk(0, 32'h00, 1, 0, 1, 32'h44, 5);
        vecs[14] = mk(0, 32'h00, 1, 0, 1, 32'h55, 4);
        vecs[15] = mk(0, 32'h00, 1, 0, 1, 32'h66, 3);
        vecs[16] = mk(0, 32'h00, 1, 0, 1, 32'h77, 2);
        vecs[17] = mk(0, 32'h00, 1, 0, 1, 32'h88, 1);
        vecs[18] = mk(0, 32'h00, 1, 0, 0, 32'h88, 0);

        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset count", 64'(count), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset ram_wen", 64'(ram_wen), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) apply_vec(i);

        // Fill: word 0 bypasses, words 1..256 land at RAM addresses 0..255.
        out_ready = 1'b0;
        for (int i = 0; i < 258; i++) begin
            in_valid = 1'b1;
            in_data  = DWL'(i);
            #1;
            check($sformatf("fill%0d in_ready", i), 64'(in_ready), 64'(i < 257));
            check($sformatf("fill%0d ram_wen", i), 64'(ram_wen), 64'(i >= 1 && i < 257));
            if (i >= 1 && i < 257)
                check($sformatf("fill%0d ram_addr", i), 64'(ram_addr), 64'(i - 1));
            step();
        end
        in_valid = 1'b0;
        #1;
        check("full count", 64'(count), 64'd257);
        check("full out_valid", 64'(out_valid), 64'd1);
        check("full out_data", 64'(out_data), 64'd0);

        // Drain one word per cycle in accepted order.
        out_ready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            check($sformatf("drain%0d out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d out_data", k), 64'(out_data), 64'(k));
            step();
        end
        check("drained out_valid", 64'(out_valid), 64'd0);
        check("drained count", 64'(count), 64'd0);

        for (int i = 3; i < 19; i++) apply_vec(i);

        // Random streaming long enough that both pointers wrap.
        sent = 0; received = 0; cycles = 0;
        prev_wr = -1; prev_rd = -1;
        saw_wr_wrap = 1'b0; saw_rd_wrap = 1'b0;
        while (received < 300 && cycles < 20000) begin
            in_valid  = (sent < 300) && ($urandom_range(0, 9) != 0);
            in_data   = in_valid ? 32'h1000_0000 + DWL'(sent) : DWL'($urandom);
            out_ready = (sent < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            if (ram_wen) begin
                if (prev_wr == 255 && ram_addr == 8'd0) saw_wr_wrap = 1'b1;
                prev_wr = int'(ram_addr);
            end else begin
                if (prev_rd == 255 && ram_addr == 8'd0) saw_rd_wrap = 1'b1;
                prev_rd = int'(ram_addr);
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check($sformatf("stream%0d unexpected word", received), 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_word = sb.pop_front();
                    check($sformatf("stream%0d order", received), 64'(out_data), 64'(exp_word));
                end
                received++;
            end
            step();
            cycles++;
        end
        check("stream words received", 64'(received), 64'd300);
        check("stream wr_ptr wrapped", 64'(saw_wr_wrap), 64'd1);
        check("stream rd_ptr wrapped", 64'(saw_rd_wrap), 64'd1);
        check("stream final count", 64'(count), 64'd0);

        // Mid-operation reset at count=10 clears state without a clock edge.
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000 + DWL'(i);
            step();
        end
        check("preload count", 64'(count), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset count", 64'(count), 64'd0);
        check("async reset in_ready", 64'(in_ready), 64'd0);
        check("async reset ram_wen", 64'(ram_wen), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        in_data = 32'hBEEF;
        step();
        check("post reset out_valid", 64'(out_valid), 64'd1);
        check("post reset out_data", 64'(out_data), 64'hBEEF);
        check("post reset count", 64'(count), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("post reset drained out_valid", 64'(out_valid), 64'd0);
        check("post reset drained count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
